mem_arbiter: RTL and testbench

- Two-requester arbiter for the single-port 64K x 8 synchronous system memory (1-cycle registered read, write-or-read per cycle).
- Port 0 is the 6502 core; port 1 is a secondary master (DMA / debug loader).
- Selects one access per cycle and steers it onto the memory port.
- Returns read data with a per-port valid strobe; supports a lock for read-modify-write sequences.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Two-port arbiter for a 64Kx8 single-port SRAM: lock, fixed/round-robin priority, starvation escape.
// Grant is combinational (0 cycles), read data returns 1 cycle after grant; a losing port holds REQ until granted.
module mem_arbiter #(
  parameter int RR_MODE      = 0,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WE0,
  input  logic        WE1,
  input  logic [15:0] ADDR0,
  input  logic [15:0] ADDR1,
  input  logic [7:0]  WDATA0,
  input  logic [7:0]  WDATA1,
  input  logic        LOCK0,
  input  logic        LOCK1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        RVALID0,
  output logic        RVALID1,
  output logic [7:0]  RDATA,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_DIN,
  input  logic [7:0]  MEM_DOUT
);

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } acc_t;

  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STARVE_LIMIT);
  localparam bit               STARVE_EN = (STARVE_LIMIT != 0);
  localparam bit               RR_EN     = (RR_MODE != 0);

  logic             lock_valid;
  logic             lock_id;
  logic             last_winner;
  logic [CNT_W-1:0] starve_cnt;
  logic             pick0;
  logic             pick1;
  logic             owner_req;
  logic             owner_gnt;
  acc_t             acc0;
  acc_t             acc1;
  acc_t             acc_sel;

  assign acc0 = '{we: WE0, addr: ADDR0, wdata: WDATA0};
  assign acc1 = '{we: WE1, addr: ADDR1, wdata: WDATA1};

  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (lock_valid) begin
      if (lock_id) pick1 = REQ1;
      else         pick0 = REQ0;
    end else if (REQ0 && REQ1) begin
      if (RR_EN) begin
        // last_winner resets to 1, so the first contention goes to port 0
        pick0 = last_winner;
        pick1 = ~last_winner;
      end else if (STARVE_EN && (starve_cnt == LIMIT)) begin
        pick1 = 1'b1;
      end else begin
        pick0 = 1'b1;
      end
    end else begin
      pick0 = REQ0;
      pick1 = REQ1;
    end
  end

  // Grants are forced low for the whole reset assertion, not just at the edge.
  assign GNT0 = pick0 & RESET_N;
  assign GNT1 = pick1 & RESET_N;

  // Idle cycles present port 0's address as a harmless read.
  assign acc_sel  = GNT1 ? acc1 : acc0;
  assign MEM_WE   = (GNT0 | GNT1) & acc_sel.we;
  assign MEM_ADDR = acc_sel.addr;
  assign MEM_DIN  = acc_sel.wdata;
  assign RDATA    = MEM_DOUT;

  assign owner_req = lock_id ? REQ1 : REQ0;
  assign owner_gnt = lock_id ? GNT1 : GNT0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
    end else begin
      RVALID0 <= GNT0 & ~WE0;
      RVALID1 <= GNT1 & ~WE1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_valid <= 1'b0;
      lock_id    <= 1'b0;
    end else if (GNT0 && LOCK0) begin
      lock_valid <= 1'b1;
      lock_id    <= 1'b0;
    end else if (GNT1 && LOCK1) begin
      lock_valid <= 1'b1;
      lock_id    <= 1'b1;
    end else if (lock_valid && (owner_gnt || !owner_req)) begin
      // final unlocked access, or the owner walked away
      lock_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_winner <= 1'b1;
    end else if (GNT0) begin
      last_winner <= 1'b0;
    end else if (GNT1) begin
      last_winner <= 1'b1;
    end
  end

  // Counts port 1 denials even while locked out, so it fires right after release.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      starve_cnt <= '0;
    end else if (RR_EN || GNT1 || !REQ1) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter: instance 0 fixed priority (starve limit 3), instance 1 round robin.
// Directed vector table, hand sequences for RR/reset, then random traffic against a rule-level model.
module tb_mem_arbiter;

  localparam int SL = 3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RESET_N;

  logic        req0 [2], we0 [2], lock0 [2], req1 [2], we1 [2], lock1 [2];
  logic [15:0] addr0 [2], addr1 [2];
  logic [7:0]  wd0 [2], wd1 [2];
  logic        gnt0 [2], gnt1 [2], rv0 [2], rv1 [2], mwe [2];
  logic [7:0]  rdata [2], mdin [2], mdout [2];
  logic [15:0] maddr [2];

  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    case (a)
      16'h0037: return 8'hDD;
      16'h0110: return 8'hBB;
      16'h02FF: return 8'h77;
      16'h0200: return 8'h00;
      default:  return a[7:0] ^ a[15:8] ^ 8'h3C;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    logic [7:0] sram [65536];
    mem_arbiter #(.RR_MODE(g), .STARVE_LIMIT(SL), .CNT_W(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ0(req0[g]), .REQ1(req1[g]), .WE0(we0[g]), .WE1(we1[g]),
      .ADDR0(addr0[g]), .ADDR1(addr1[g]), .WDATA0(wd0[g]), .WDATA1(wd1[g]),
      .LOCK0(lock0[g]), .LOCK1(lock1[g]), .GNT0(gnt0[g]), .GNT1(gnt1[g]),
      .RVALID0(rv0[g]), .RVALID1(rv1[g]), .RDATA(rdata[g]),
      .MEM_WE(mwe[g]), .MEM_ADDR(maddr[g]), .MEM_DIN(mdin[g]), .MEM_DOUT(mdout[g])
    );
    initial for (int a = 0; a < 65536; a++) sram[a] = init_val(16'(a));
    always @(posedge CLK) begin
      mdout[g] <= sram[maddr[g]];
      if (mwe[g]) sram[maddr[g]] = mdin[g];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic r0, w0, l0; logic [15:0] a0; logic [7:0] d0;
    logic r1, w1, l1; logic [15:0] a1; logic [7:0] d1;
    logic g0, g1, mw; logic [15:0] ma; logic [7:0] md;
    logic v0, v1; logic [7:0] rd;
  } vec_t;

  function automatic vec_t mk(input int r0, w0, l0, a0, d0, r1, w1, l1, a1, d1,
                              g0, g1, mw, ma, md, v0, v1, rd);
    vec_t v;
    v.r0 = r0[0]; v.w0 = w0[0]; v.l0 = l0[0]; v.a0 = 16'(a0); v.d0 = 8'(d0);
    v.r1 = r1[0]; v.w1 = w1[0]; v.l1 = l1[0]; v.a1 = 16'(a1); v.d1 = 8'(d1);
    v.g0 = g0[0]; v.g1 = g1[0]; v.mw = mw[0]; v.ma = 16'(ma); v.md = 8'(md);
    v.v0 = v0[0]; v.v1 = v1[0]; v.rd = 8'(rd);
    return v;
  endfunction

  task automatic drive_vec(input int k, input vec_t v);
    req0[k] = v.r0; we0[k] = v.w0; lock0[k] = v.l0; addr0[k] = v.a0; wd0[k] = v.d0;
    req1[k] = v.r1; we1[k] = v.w1; lock1[k] = v.l1; addr1[k] = v.a1; wd1[k] = v.d1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) drive_vec(k, mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0));
  endtask

  task automatic check_vec(input int k, input vec_t v, input string tag);
    chk({tag, ".gnt0"}, 32'(gnt0[k]), 32'(v.g0));
    chk({tag, ".gnt1"}, 32'(gnt1[k]), 32'(v.g1));
    chk({tag, ".mem_we"}, 32'(mwe[k]), 32'(v.mw));
    chk({tag, ".mem_addr"}, 32'(maddr[k]), 32'(v.ma));
    chk({tag, ".mem_din"}, 32'(mdin[k]), 32'(v.md));
    chk({tag, ".rvalid0"}, 32'(rv0[k]), 32'(v.v0));
    chk({tag, ".rvalid1"}, 32'(rv1[k]), 32'(v.v1));
    if (v.v0 || v.v1) chk({tag, ".rdata"}, 32'(rdata[k]), 32'(v.rd));
  endtask

  // ---------------- reference model: arbitration rules stated directly ----------------
  int          m_owner [2];       // -1: no lock, else owning port
  int          m_last [2];
  int          m_denied [2];      // consecutive cycles port 1 requested and lost
  logic        m_pv [2][2];
  logic [7:0]  m_pd [2][2];
  logic        m_gp [2][2];       // port granted in previous cycle
  logic [7:0]  refm [2][65536];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_last[k] = 1; m_denied[k] = 0;
      for (int p = 0; p < 2; p++) begin m_pv[k][p] = 1'b0; m_gp[k][p] = 1'b0; end
    end
  endtask

  function automatic int model_grant(input int k);
    logic rq [2];
    rq[0] = req0[k]; rq[1] = req1[k];
    if (m_owner[k] >= 0) return rq[m_owner[k]] ? m_owner[k] : -1;
    if (rq[0] && rq[1]) begin
      if (k == 1) return 1 - m_last[k];
      return (m_denied[k] >= SL) ? 1 : 0;
    end
    if (rq[0]) return 0;
    if (rq[1]) return 1;
    return -1;
  endfunction

  task automatic model_step(input int k, input string tag);
    int win;
    logic        w [2], l [2], rq [2];
    logic [15:0] a [2];
    logic [7:0]  d [2];
    logic        ewe;
    rq[0] = req0[k]; rq[1] = req1[k]; w[0] = we0[k]; w[1] = we1[k];
    l[0] = lock0[k]; l[1] = lock1[k]; a[0] = addr0[k]; a[1] = addr1[k];
    d[0] = wd0[k]; d[1] = wd1[k];
    win = model_grant(k);
    ewe = (win >= 0) ? w[win] : 1'b0;
    chk({tag, ".gnt0"}, 32'(gnt0[k]), 32'(win == 0));
    chk({tag, ".gnt1"}, 32'(gnt1[k]), 32'(win == 1));
    chk({tag, ".mem_we"}, 32'(mwe[k]), 32'(ewe));
    chk({tag, ".mem_addr"}, 32'(maddr[k]), 32'((win == 1) ? a[1] : a[0]));
    chk({tag, ".mem_din"}, 32'(mdin[k]), 32'((win == 1) ? d[1] : d[0]));
    chk({tag, ".rvalid0"}, 32'(rv0[k]), 32'(m_pv[k][0]));
    chk({tag, ".rvalid1"}, 32'(rv1[k]), 32'(m_pv[k][1]));
    for (int p = 0; p < 2; p++)
      if (m_pv[k][p]) chk({tag, ".rdata"}, 32'(rdata[k]), 32'(m_pd[k][p]));
    // advance to the next cycle
    for (int p = 0; p < 2; p++) begin
      m_pv[k][p] = (win == p) && !w[p];
      if (win == p) m_pd[k][p] = refm[k][a[p]];
      m_gp[k][p] = (win == p);
    end
    if (win >= 0 && w[win]) refm[k][a[win]] = d[win];
    if (win >= 0 && l[win]) m_owner[k] = win;
    else if (m_owner[k] >= 0 && (win == m_owner[k] || !rq[m_owner[k]])) m_owner[k] = -1;
    if (win >= 0) m_last[k] = win;
    if (rq[1] && win != 1) m_denied[k] = (m_denied[k] < SL) ? m_denied[k] + 1 : SL;
    else m_denied[k] = 0;
  endtask

  typedef struct packed { logic r, w, l; logic [15:0] a; logic [7:0] d; } preq_t;

  // Holds an ungranted request stable; occasionally withdraws it.
  function automatic preq_t gen(input preq_t cur, input logic granted);
    preq_t n;
    n = cur;
    if (!cur.r || granted) begin
      n.r = ($urandom_range(0, 9) < 6);
      n.w = ($urandom_range(0, 2) == 0);
      n.l = ($urandom_range(0, 3) == 0);
      n.a = 16'($urandom_range(0, 31));
      n.d = 8'($urandom);
    end else if ($urandom_range(0, 11) == 0) begin
      n.r = 1'b0;
    end
    return n;
  endfunction

  vec_t tbl [20];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 65536; a++) refm[k][a] = init_val(16'(a));

    // reset: requests present but nothing may be issued
    RESET_N = 1'b0;
    for (int k = 0; k < 2; k++) drive_vec(k, mk(1,1,1,'h0010,'h44, 1,1,1,'h0020,'h55, 0,0,0,0,0, 0,0,0));
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d.gnt0", k), 32'(gnt0[k]), 0);
      chk($sformatf("rst%0d.gnt1", k), 32'(gnt1[k]), 0);
      chk($sformatf("rst%0d.mem_we", k), 32'(mwe[k]), 0);
      chk($sformatf("rst%0d.rvalid0", k), 32'(rv0[k]), 0);
      chk($sformatf("rst%0d.rvalid1", k), 32'(rv1[k]), 0);
    end
    idle_all();
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    //        r0 w0 l0 a0      d0    r1 w1 l1 a1      d1     g0 g1 mw ma      md     v0 v1 rd
    tbl[0]  = mk(1,0,0,'h0037,0,     0,0,0,0,0,         1,0,0,'h0037,0,     0,0,0);
    tbl[1]  = mk(0,0,0,0,0,          0,0,0,0,0,         0,0,0,0,0,          1,0,'hDD);
    tbl[2]  = mk(1,0,0,'h0037,0,     1,0,0,'h0110,0,    1,0,0,'h0037,0,     0,0,0);
    tbl[3]  = mk(1,0,0,'h0037,0,     1,0,0,'h0110,0,    1,0,0,'h0037,0,     1,0,'hDD);
    tbl[4]  = mk(1,0,0,'h0037,0,     1,0,0,'h0110,0,    1,0,0,'h0037,0,     1,0,'hDD);
    tbl[5]  = mk(1,0,0,'h0037,0,     1,0,0,'h0110,0,    0,1,0,'h0110,0,     1,0,'hDD);
    tbl[6]  = mk(1,0,0,'h0037,0,     1,0,0,'h0110,0,    1,0,0,'h0037,0,     0,1,'hBB);
    tbl[7]  = mk(1,0,0,'h0037,0,     1,0,0,'h0110,0,    1,0,0,'h0037,0,     1,0,'hDD);
    tbl[8]  = mk(1,0,0,'h0037,0,     1,0,0,'h0110,0,    1,0,0,'h0037,0,     1,0,'hDD);
    tbl[9]  = mk(1,0,0,'h0037,0,     1,0,0,'h0110,0,    0,1,0,'h0110,0,     1,0,'hDD);
    tbl[10] = mk(0,0,0,0,0,          0,0,0,0,0,         0,0,0,0,0,          0,1,'hBB);
    tbl[11] = mk(1,0,1,'h02FF,0,     1,0,0,'h0110,0,    1,0,0,'h02FF,0,     0,0,0);
    tbl[12] = mk(1,1,1,'h02FF,'h11,  1,0,0,'h0110,0,    1,0,1,'h02FF,'h11,  1,0,'h77);
    tbl[13] = mk(1,0,0,'h02FF,0,     1,0,0,'h0110,0,    1,0,0,'h02FF,0,     0,0,0);
    tbl[14] = mk(1,0,0,'h0037,0,     1,0,0,'h0110,0,    0,1,0,'h0110,0,     1,0,'h11);
    tbl[15] = mk(1,0,0,'h0037,0,     0,0,0,0,0,         1,0,0,'h0037,0,     0,1,'hBB);
    tbl[16] = mk(0,0,0,0,0,          0,0,0,0,0,         0,0,0,0,0,          1,0,'hDD);
    tbl[17] = mk(0,0,0,0,0,          1,1,0,'h0200,'h5A, 0,1,1,'h0200,'h5A,  0,0,0);
    tbl[18] = mk(1,0,0,'h0200,0,     0,0,0,0,0,         1,0,0,'h0200,0,     0,0,0);
    tbl[19] = mk(0,0,0,0,0,          0,0,0,0,0,         0,0,0,0,0,          1,0,'h5A);

    for (int i = 0; i < 20; i++) begin
      drive_vec(0, tbl[i]);
      @(negedge CLK);
      check_vec(0, tbl[i], $sformatf("tbl%0d", i));
      @(posedge CLK); #1;
    end
    idle_all();

    // round robin on instance 1: alternation starting with port 0
    v = mk(1,0,0,'h0037,0, 1,0,0,'h0110,0, 0,0,0,0,0, 0,0,0);
    for (int i = 0; i < 6; i++) begin
      drive_vec(1, v);
      @(negedge CLK);
      chk($sformatf("rr%0d.gnt0", i), 32'(gnt0[1]), 32'(i % 2 == 0));
      chk($sformatf("rr%0d.gnt1", i), 32'(gnt1[1]), 32'(i % 2 == 1));
      chk($sformatf("rr%0d.rvalid1", i), 32'(rv1[1]), 32'(i > 0 && i % 2 == 0));
      chk($sformatf("rr%0d.rvalid0", i), 32'(rv0[1]), 32'(i > 0 && i % 2 == 1));
      if (i > 0) chk($sformatf("rr%0d.rdata", i), 32'(rdata[1]), (i % 2 == 0) ? 32'hBB : 32'hDD);
      @(posedge CLK); #1;
    end
    idle_all();
    @(posedge CLK); #1;

    // asynchronous reset while port 0 holds a lock and a read is in flight
    drive_vec(0, mk(1,0,1,'h02FF,0, 1,0,0,'h0110,0, 0,0,0,0,0, 0,0,0));
    @(negedge CLK);
    chk("arst.setup_gnt0", 32'(gnt0[0]), 1);
    @(posedge CLK); #1;
    drive_vec(0, mk(1,1,1,'h02FF,'h99, 1,0,0,'h0110,0, 0,0,0,0,0, 0,0,0));
    #1;
    chk("arst.pre_gnt0", 32'(gnt0[0]), 1);
    chk("arst.pre_mem_we", 32'(mwe[0]), 1);
    chk("arst.pre_rvalid0", 32'(rv0[0]), 1);
    RESET_N = 1'b0;
    #1;
    chk("arst.gnt0", 32'(gnt0[0]), 0);
    chk("arst.gnt1", 32'(gnt1[0]), 0);
    chk("arst.mem_we", 32'(mwe[0]), 0);
    chk("arst.rvalid0", 32'(rv0[0]), 0);
    #1;
    RESET_N = 1'b1;
    drive_vec(0, mk(0,0,0,0,0, 1,0,0,'h0110,0, 0,0,0,0,0, 0,0,0));
    @(negedge CLK);
    chk("arst.after_gnt1", 32'(gnt1[0]), 1);
    chk("arst.after_gnt0", 32'(gnt0[0]), 0);
    @(posedge CLK); #1;
    idle_all();

    // random traffic on both instances against the model
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        preq_t p0, p1;
        p0 = gen('{r: req0[k], w: we0[k], l: lock0[k], a: addr0[k], d: wd0[k]}, m_gp[k][0]);
        p1 = gen('{r: req1[k], w: we1[k], l: lock1[k], a: addr1[k], d: wd1[k]}, m_gp[k][1]);
        req0[k] = p0.r; we0[k] = p0.w; lock0[k] = p0.l; addr0[k] = p0.a; wd0[k] = p0.d;
        req1[k] = p1.r; we1[k] = p1.w; lock1[k] = p1.l; addr1[k] = p1.a; wd1[k] = p1.d;
      end
      @(negedge CLK);
      for (int k = 0; k < 2; k++) model_step(k, $sformatf("rnd%0d.c%0d", k, c));
      @(posedge CLK); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
